instr_prefetch_queue: RTL and testbench

Decoupled instruction-fetch front end that sits directly upstream of the decode/execute stage. It issues sequential word fetches to an instruction-memory port with a valid/ready request and an in-order response. It buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready handshake. A branch/jump redirect from decode/execute flushes the queue, discards in-flight responses and restarts fetch at the redirect target.

---
 rtl/instr_prefetch_queue.sv | 122 ++++++++++++
 tb/tb_instr_prefetch_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential imem fetch, DEPTH-entry {pc, instr} FIFO, redirect flush.
// Optional macro PREFETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t         DEPTH_C = cnt_t'(DEPTH);
    localparam logic [CW:0]  DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0] fetch_pc;
    logic [31:0] q_pc    [DEPTH];
    logic [31:0] q_instr [DEPTH];
    ptr_t        rd_ptr, wr_ptr;
    cnt_t        count;
    cnt_t        inflight, drop;
    logic [31:0] pend_pc [DEPTH];
    ptr_t        pend_rd, pend_wr;

    logic        req_fire;
    logic        rsp_push;
    logic        pop;
    logic        head_valid;
    logic [CW:0] occupancy;

    assign head_valid = (count != '0);
    assign occupancy  = {1'b0, count} + {1'b0, inflight} - {1'b0, drop};

    // The inflight bound keeps the request-address FIFO from overflowing across repeated redirects.
    assign imem_req_valid = !reset && !redirect && (occupancy < DEPTH_W) && (inflight < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

`ifdef PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass    = !head_valid && (drop == '0) && imem_rsp_valid && !redirect;
    assign dec_valid = (head_valid || bypass) && !redirect;
    assign dec_instr = head_valid ? q_instr[rd_ptr] : (bypass ? imem_rsp_data : '0);
    assign dec_pc    = head_valid ? q_pc[rd_ptr]    : (bypass ? pend_pc[pend_rd] : '0);
    assign rsp_push  = imem_rsp_valid && !redirect && (drop == '0) && !(bypass && dec_ready);
`else
    assign dec_valid = head_valid && !redirect;
    assign dec_instr = head_valid ? q_instr[rd_ptr] : '0;
    assign dec_pc    = head_valid ? q_pc[rd_ptr]    : '0;
    assign rsp_push  = imem_rsp_valid && !redirect && (drop == '0);
`endif

    assign pop = head_valid && dec_valid && dec_ready;

    always_ff @(posedge clock) begin
        if (req_fire) begin
            pend_pc[pend_wr] <= fetch_pc;
        end
        if (rsp_push) begin
            q_pc[wr_ptr]    <= pend_pc[pend_rd];
            q_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            pend_rd  <= '0;
            pend_wr  <= '0;
        end else begin
            // Request addresses are tracked through redirects so every response stays paired.
            if (req_fire) begin
                pend_wr <= pend_wr + 1'b1;
            end
            if (imem_rsp_valid) begin
                pend_rd <= pend_rd + 1'b1;
            end
            inflight <= inflight + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);

            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop     <= inflight - cnt_t'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                if (rsp_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + cnt_t'(rsp_push) - cnt_t'(pop);
            end
        end
    end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with an in-order imem model of configurable latency.
// Memory word at address a is a ^ 32'hC0DE_0000.
module tb_instr_prefetch_queue;
    localparam int unsigned DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    int unsigned total = 0;
    int unsigned bad = 0;

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       pend[$];
    int unsigned mem_lat = 1;
    int unsigned req_count = 0;

    // Inputs change at negedge; the memory reacts 1 time unit later, checks happen 3 units after negedge.
    always @(negedge clock) begin
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (reset) begin
            pend.delete();
            req_count = 0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{imem_req_addr, cyc + mem_lat});
                req_count = req_count + 1;
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                assert (pend.size() != 0) else $error("response with nothing outstanding");
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend[0].addr ^ 32'hC0DE_0000;
                void'(pend.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic reset_dut(input int unsigned lat);
        @(negedge clock);
        reset    = 1'b1;
        redirect = 1'b0;
        mem_lat  = lat;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clock);
        #3;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset req_valid: got %b want 0", imem_req_valid); end
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL reset req_addr: got %h want 00000000", imem_req_addr); end
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL reset dec_valid: got %b want 0", dec_valid); end
        total++; if (dec_instr !== 32'h0) begin bad++; $display("FAIL reset dec_instr: got %h want 00000000", dec_instr); end
        total++; if (dec_pc !== 32'h0) begin bad++; $display("FAIL reset dec_pc: got %h want 00000000", dec_pc); end
    endtask

    task automatic test_stream;
        logic [31:0] exp_pc;
        dec_ready = 1'b1;
        reset_dut(1);
        #3;
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL stream first req_valid: got %b want 1", imem_req_valid); end
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL stream first req_addr: got %h want 00000000", imem_req_addr); end
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL stream c0 dec_valid: got %b want 0", dec_valid); end
        @(negedge clock); #3;
        total++; if (dec_valid !== BYP) begin bad++; $display("FAIL stream rsp-cycle dec_valid: got %b want %b", dec_valid, BYP); end
        if (!BYP) begin
            @(negedge clock); #3;
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(negedge clock); #3;
            end
            exp_pc = 32'(k * 4);
            total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL stream valid[%0d]: got %b want 1", k, dec_valid); end
            total++; if (dec_pc !== exp_pc) begin bad++; $display("FAIL stream pc[%0d]: got %h want %h", k, dec_pc, exp_pc); end
            total++; if (dec_instr !== (exp_pc | 32'hC0DE_0000)) begin bad++; $display("FAIL stream instr[%0d]: got %h want %h", k, dec_instr, exp_pc | 32'hC0DE_0000); end
        end
    endtask

    task automatic test_stall;
        logic [31:0] exp_pc;
        dec_ready = 1'b0;
        reset_dut(1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clock);
            #3;
        end
        total++; if (req_count !== 4) begin bad++; $display("FAIL stall req_count: got %0d want 4", req_count); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall req_valid: got %b want 0", imem_req_valid); end
        total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin bad++; $display("FAIL stall head: got valid=%b pc=%h want valid=1 pc=00000000", dec_valid, dec_pc); end
        @(negedge clock);
        dec_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clock);
            #3;
            exp_pc = 32'(k * 4);
            total++; if (dec_valid !== 1'b1 || dec_pc !== exp_pc) begin bad++; $display("FAIL stall drain[%0d]: got valid=%b pc=%h want pc=%h", k, dec_valid, dec_pc, exp_pc); end
        end
    endtask

    task automatic test_redirect;
        logic        got;
        logic [31:0] exp_pc;
        dec_ready = 1'b1;
        reset_dut(3);
        for (int c = 0; c < 5; c++) @(negedge clock);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        #3;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL redirect cycle dec_valid: got %b want 0", dec_valid); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redirect cycle req_valid: got %b want 0", imem_req_valid); end
        @(negedge clock);
        redirect = 1'b0;
        #3;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin bad++; $display("FAIL redirect restart req: got valid=%b addr=%h want 1/00000100", imem_req_valid, imem_req_addr); end
        got = dec_valid;
        for (int e = 0; e < 3; e++) begin
            if (e > 0) got = 1'b0;
            for (int w = 0; w < 12 && !got; w++) begin
                @(negedge clock); #3;
                got = dec_valid;
            end
            exp_pc = 32'h100 + 32'(e * 4);
            total++; if (!got || dec_pc !== exp_pc) begin bad++; $display("FAIL redirect pc[%0d]: got valid=%b pc=%h want %h", e, got, dec_pc, exp_pc); end
        end
    endtask

    task automatic test_coincident;
        logic        got;
        logic [31:0] exp_pc;
        dec_ready = 1'b1;
        reset_dut(1);
        for (int c = 0; c < 3; c++) @(negedge clock);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        #3;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL coincident dec_valid: got %b want 0", dec_valid); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL coincident req_valid: got %b want 0", imem_req_valid); end
        got = 1'b0;
        for (int w = 0; w < 12 && !got; w++) begin
            @(negedge clock); redirect = 1'b0; #3;
            got = dec_valid;
        end
        total++; if (!got || dec_pc !== 32'h200) begin bad++; $display("FAIL coincident first pc: got valid=%b pc=%h want 00000200", got, dec_pc); end
        total++; if (dec_instr !== 32'hC0DE_0200) begin bad++; $display("FAIL coincident first instr: got %h want c0de0200", dec_instr); end
        got = 1'b0;
        for (int w = 0; w < 12 && !got; w++) begin
            @(negedge clock); #3;
            got = dec_valid;
        end
        exp_pc = 32'h204;
        total++; if (!got || dec_pc !== exp_pc) begin bad++; $display("FAIL coincident second pc: got valid=%b pc=%h want %h", got, dec_pc, exp_pc); end
    endtask

    task automatic test_wrap;
        logic        got;
        logic [31:0] exp_pc [3];
        logic [31:0] exp_in [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_in[0] = 32'h3F21_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC; exp_in[1] = 32'h3F21_FFFC;
        exp_pc[2] = 32'h0000_0000; exp_in[2] = 32'hC0DE_0000;
        dec_ready = 1'b1;
        reset_dut(1);
        for (int c = 0; c < 2; c++) @(negedge clock);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        for (int e = 0; e < 3; e++) begin
            got = 1'b0;
            for (int w = 0; w < 12 && !got; w++) begin
                @(negedge clock); redirect = 1'b0; #3;
                got = dec_valid;
            end
            total++; if (!got || dec_pc !== exp_pc[e]) begin bad++; $display("FAIL wrap pc[%0d]: got valid=%b pc=%h want %h", e, got, dec_pc, exp_pc[e]); end
            total++; if (dec_instr !== exp_in[e]) begin bad++; $display("FAIL wrap instr[%0d]: got %h want %h", e, dec_instr, exp_in[e]); end
        end
    endtask

    task automatic test_back_to_back;
        logic        got;
        logic [31:0] exp_pc;
        dec_ready = 1'b1;
        reset_dut(3);
        for (int c = 0; c < 5; c++) @(negedge clock);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        @(negedge clock);
        redirect_pc = 32'h0000_0400;
        #3;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL b2b second cycle req_valid: got %b want 0", imem_req_valid); end
        for (int e = 0; e < 2; e++) begin
            got = 1'b0;
            for (int w = 0; w < 12 && !got; w++) begin
                @(negedge clock); redirect = 1'b0; #3;
                got = dec_valid;
            end
            exp_pc = 32'h400 + 32'(e * 4);
            total++; if (!got || dec_pc !== exp_pc) begin bad++; $display("FAIL b2b pc[%0d]: got valid=%b pc=%h want %h", e, got, dec_pc, exp_pc); end
        end
    endtask

    task automatic test_mid_reset;
        logic got;
        dec_ready = 1'b1;
        reset_dut(1);
        for (int c = 0; c < 3; c++) @(negedge clock);
        #3;
        total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL midreset pre dec_valid: got %b want 1", dec_valid); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        total++; if (dec_valid !== 1'b0 || dec_pc !== 32'h0) begin bad++; $display("FAIL midreset clear: got valid=%b pc=%h want 0/00000000", dec_valid, dec_pc); end
        total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL midreset req: got valid=%b addr=%h want 0/00000000", imem_req_valid, imem_req_addr); end
        reset_dut(1);
        got = 1'b0;
        for (int w = 0; w < 12 && !got; w++) begin
            @(negedge clock); #3;
            got = dec_valid;
        end
        total++; if (!got || dec_pc !== 32'h0) begin bad++; $display("FAIL midreset restart pc: got valid=%b pc=%h want 00000000", got, dec_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_coincident();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
